fwd_hazard_unit: RTL

Parametrised forwarding and load-use hazard unit for the pipelined CPU. It sits between decode (ID) and execute (EX). It keeps a registered scoreboard of in-flight register writes across `NSTG` pipeline stages, including load-marked writes. Each cycle it either issues the ID instruction with registered per-operand forwarding selects for EX, or stalls ID and inserts a bubble. It also counts stall cycles for performance monitoring.

---
 rtl/fwd_hazard_unit.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// -----------------------------------------------------------------------------
// fwd_hazard_unit
//
// Forwarding and load-use hazard unit sitting between decode (ID) and execute
// (EX). A registered scoreboard tracks the last NSTG register writes that left
// ID (stage 1 = EX). Each cycle the ID instruction is either issued, with a
// registered per-operand forwarding select for EX, or stalled while a bubble
// enters EX. Stall cycles are counted with saturation for performance
// monitoring.
//
// Parameters
//   AW        register address width
//   NSRC      source operands per instruction
//   NSTG      scoreboard depth (stage 1 = EX)
//   LOAD_LAT  stages after EX before load data becomes forwardable
//   SW        width of one select field (derived, do not override)
//
// Ports
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   issue_valid_i  ID holds a valid instruction
//   issue_wen_i    ID instruction writes a register
//   issue_waddr_i  ID destination register
//   issue_load_i   ID instruction is a load
//   src_addr_i     ID source registers, operand n at [n*AW +: AW]
//   src_used_i     per-operand "source is read" flag
//   flush_i        kill the ID instruction this cycle
//   stall_o        hold PC/IF/ID, bubble into EX (combinational)
//   fwd_sel_o      registered selects for the instruction in EX
//                  (0 = register file, k = producer k stages ahead of EX)
//   stall_cnt_o    saturating stall-cycle counter
// -----------------------------------------------------------------------------
module fwd_hazard_unit #(
    parameter int unsigned AW       = 5,
    parameter int unsigned NSRC     = 2,
    parameter int unsigned NSTG     = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SW       = $clog2(NSTG + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 issue_valid_i,
    input  logic                 issue_wen_i,
    input  logic [AW-1:0]        issue_waddr_i,
    input  logic                 issue_load_i,
    input  logic [NSRC*AW-1:0]   src_addr_i,
    input  logic [NSRC-1:0]      src_used_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    output logic [NSRC*SW-1:0]   fwd_sel_o,
    output logic [15:0]          stall_cnt_o
);

    localparam int unsigned CW = 16;

    // Scoreboard records, index 1 = instruction currently in EX
    logic [NSTG:1]   vld_q,  vld_d;
    logic [AW-1:0]   addr_q [1:NSTG];
    logic [AW-1:0]   addr_d [1:NSTG];
    logic [NSTG:1]   load_q, load_d;

    logic [NSRC*SW-1:0] fwd_sel_q, fwd_sel_d;
    logic [CW-1:0]      cnt_q,     cnt_d;

    logic [NSRC*SW-1:0] sel_c;
    logic               hazard_c;
    logic               issue_c;

    // Youngest-match search per operand: select and load-use hazard
    always_comb begin : match_blk
        logic [AW-1:0] sa;
        logic          hit;
        logic          fwd_ok;
        logic [SW-1:0] hit_j;
        hazard_c = 1'b0;
        sel_c    = '0;
        sa       = '0;
        hit      = 1'b0;
        fwd_ok   = 1'b0;
        hit_j    = '0;
        for (int unsigned n = 0; n < NSRC; n++) begin
            sa     = src_addr_i[n*AW +: AW];
            hit    = 1'b0;
            fwd_ok = 1'b0;
            hit_j  = '0;
            // Scan oldest to youngest so the youngest match overwrites
            for (int j = int'(NSTG); j >= 1; j--) begin
                if (src_used_i[n] && (sa != '0) && vld_q[j] && (addr_q[j] == sa)) begin
                    hit    = 1'b1;
                    hit_j  = SW'(j);
                    fwd_ok = !load_q[j] || (j > int'(LOAD_LAT));
                end
            end
            if (hit && fwd_ok) begin
                sel_c[n*SW +: SW] = hit_j;
            end
            hazard_c = hazard_c | (hit & ~fwd_ok);
        end
    end

    // Flush wins over both stall and issue
    assign stall_o = issue_valid_i & ~flush_i & hazard_c;
    assign issue_c = issue_valid_i & ~flush_i & ~hazard_c;

    // Scoreboard shift; a bubble enters stage 1 unless the ID instruction issues
    always_comb begin
        vld_d  = '0;
        load_d = '0;
        for (int j = 1; j <= int'(NSTG); j++) begin
            addr_d[j] = '0;
        end
        if (issue_c) begin
            vld_d[1]  = issue_wen_i & (issue_waddr_i != '0);
            addr_d[1] = issue_waddr_i;
            load_d[1] = issue_load_i;
        end
        for (int j = 2; j <= int'(NSTG); j++) begin
            vld_d[j]  = vld_q[j-1];
            addr_d[j] = addr_q[j-1];
            load_d[j] = load_q[j-1];
        end
    end

    // Select register and saturating stall counter next state
    always_comb begin
        fwd_sel_d = issue_c ? sel_c : '0;
        cnt_d     = cnt_q;
        if (stall_o && (cnt_q != {CW{1'b1}})) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            load_q    <= '0;
            fwd_sel_q <= '0;
            cnt_q     <= '0;
            for (int j = 1; j <= int'(NSTG); j++) begin
                addr_q[j] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            load_q    <= load_d;
            fwd_sel_q <= fwd_sel_d;
            cnt_q     <= cnt_d;
            for (int j = 1; j <= int'(NSTG); j++) begin
                addr_q[j] <= addr_d[j];
            end
        end
    end

    assign fwd_sel_o   = fwd_sel_q;
    assign stall_cnt_o = cnt_q;

endmodule
